// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types and Gray decode helper for the Gray position tracker
package gray_pkg;

    localparam int ERR_CNT_W  = 8;
    localparam int GRAY_MAX_W = 32;

    typedef enum logic [0:0] {
        SEED  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Upper bits are zero after extension, so they also decode to zero.
    // The result therefore holds for any WIDTH up to GRAY_MAX_W.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - multi-flop synchroniser for a Gray word crossing into this clock domain
module gray_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/gray_track_decoder.sv
// rtl/gray_track_decoder.sv - tracks a synchronised Gray position, flags +/-1 steps and illegal jumps
module gray_track_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [WIDTH-1:0]     i_gray_in,
    input  logic                 i_clr,
    output logic [WIDTH-1:0]     o_bin_out,
    output logic                 o_pos_valid,
    output logic                 o_dir,
    output logic                 o_step_err,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0]     w_g_sync;
    logic [WIDTH-1:0]     w_b_new;
    logic [WIDTH-1:0]     w_diff;

    state_t               r_state;
    logic [CNT_W-1:0]     r_seed_cnt;
    logic [WIDTH-1:0]     r_b_prev;
    logic                 r_pos_valid;
    logic                 r_dir;
    logic                 r_step_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    gray_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_gray_in),
        .o_sync  (w_g_sync)
    );

    assign w_b_new = WIDTH'(gray2bin(GRAY_MAX_W'(w_g_sync)));
    assign w_diff  = w_b_new - r_b_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= SEED;
            r_seed_cnt  <= '0;
            r_b_prev    <= '0;
            r_pos_valid <= 1'b0;
            r_dir       <= 1'b0;
            r_step_err  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_pos_valid <= 1'b0;
            case (r_state)
                // Synchroniser still holds reset zeros until it has filled.
                SEED: begin
                    if (r_seed_cnt == CNT_W'(SYNC_STAGES)) begin
                        r_b_prev <= w_b_new;
                        r_state  <= TRACK;
                    end else begin
                        r_seed_cnt <= r_seed_cnt + 1'b1;
                    end
                end
                TRACK: begin
                    r_b_prev <= w_b_new;
                    if (w_diff == WIDTH'(1)) begin
                        r_pos_valid <= 1'b1;
                        r_dir       <= 1'b1;
                    end else if (w_diff == '1) begin
                        r_pos_valid <= 1'b1;
                        r_dir       <= 1'b0;
                    end else if (w_diff != '0) begin
                        r_step_err <= 1'b1;
                        if (r_err_count != '1) begin
                            r_err_count <= r_err_count + 1'b1;
                        end
                    end
                end
                default: r_state <= SEED;
            endcase
            if (i_clr) begin
                r_step_err  <= 1'b0;
                r_err_count <= '0;
            end
        end
    end

    assign o_bin_out   = r_b_prev;
    assign o_pos_valid = r_pos_valid;
    assign o_dir       = r_dir;
    assign o_step_err  = r_step_err;
    assign o_err_count = r_err_count;

endmodule

// File: tb/tb_gray_track_decoder.sv
// tb/tb_gray_track_decoder.sv - scoreboard bench for gray_track_decoder
module tb_gray_track_decoder;

    localparam int W = 4;
    localparam int S = 2;

    typedef struct {
        logic [W-1:0] bin;
        logic         valid;
        logic         dir;
        logic         err;
        logic [7:0]   cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] gray_in = '0;
    logic         clr = 1'b0;
    logic [W-1:0] bin_out;
    logic         pos_valid;
    logic         dir;
    logic         step_err;
    logic [7:0]   err_count;

    int n_checks = 0;
    int n_errors = 0;
    int pulses = 0;
    int exp_pulses = 0;

    exp_t sb[$];

    logic [W-1:0] m_bin;
    logic         m_dir;
    logic         m_err;
    logic [7:0]   m_cnt;

    gray_track_decoder #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_gray_in   (gray_in),
        .i_clr       (clr),
        .o_bin_out   (bin_out),
        .o_pos_valid (pos_valid),
        .o_dir       (dir),
        .o_step_err  (step_err),
        .o_err_count (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (pos_valid === 1'b1) pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int k = 0; k < W; k++) b = b ^ (g >> k);
        return b;
    endfunction

    // Model predicts outcome of one synced sample and queues it.
    task automatic model_step(input logic [W-1:0] g, input logic c);
        exp_t e;
        logic [W-1:0] nb;
        logic [W-1:0] d;
        nb = from_gray(g);
        d  = nb - m_bin;
        e.valid = 1'b0;
        if (d == 4'd1) begin
            e.valid = 1'b1; m_dir = 1'b1;
        end else if (d == 4'd15) begin
            e.valid = 1'b1; m_dir = 1'b0;
        end else if (d != 4'd0) begin
            m_err = 1'b1;
            if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        end
        if (c) begin
            m_err = 1'b0; m_cnt = 8'd0;
        end
        m_bin = nb;
        if (e.valid) exp_pulses++;
        e.bin = m_bin; e.dir = m_dir; e.err = m_err; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [W-1:0] b, input logic c);
        exp_t e;
        @(negedge clk);
        gray_in = to_gray(b);
        model_step(to_gray(b), c);
        repeat (S) @(posedge clk);
        @(negedge clk);
        clr = c;
        @(posedge clk);
        #1;
        clr = 1'b0;
        e = sb.pop_front();
        chk("bin_out", 32'(bin_out), 32'(e.bin));
        chk("pos_valid", 32'(pos_valid), 32'(e.valid));
        chk("dir", 32'(dir), 32'(e.dir));
        chk("step_err", 32'(step_err), 32'(e.err));
        chk("err_count", 32'(err_count), 32'(e.cnt));
        @(posedge clk);
        #1;
        chk("pos_valid_one_cycle", 32'(pos_valid), 32'(0));
    endtask

    task automatic seed_check(input logic [W-1:0] b);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (S) begin
            @(posedge clk);
            #1;
            chk("seed_bin_early", 32'(bin_out), 32'(0));
            chk("seed_valid_early", 32'(pos_valid), 32'(0));
        end
        @(posedge clk);
        #1;
        chk("seed_bin", 32'(bin_out), 32'(b));
        chk("seed_valid", 32'(pos_valid), 32'(0));
        chk("seed_err", 32'(step_err), 32'(0));
        chk("seed_cnt", 32'(err_count), 32'(0));
        m_bin = b; m_dir = 1'b0; m_err = 1'b0; m_cnt = 8'd0;
    endtask

    initial begin
        m_bin = '0; m_dir = 1'b0; m_err = 1'b0; m_cnt = 8'd0;
        #1;
        chk("reset_bin", 32'(bin_out), 32'(0));
        chk("reset_dir", 32'(dir), 32'(0));
        repeat (2) @(posedge clk);
        seed_check(4'd0);

        for (int i = 1; i <= 16; i++) drive(4'(i), 1'b0);
        drive(4'd15, 1'b0);
        drive(4'd0, 1'b0);
        drive(4'd7, 1'b0);
        drive(4'd6, 1'b0);
        drive(4'd12, 1'b1);
        for (int i = 0; i < 300; i++) drive((i % 2 == 0) ? 4'd4 : 4'd12, 1'b0);
        drive(4'd12, 1'b1);
        for (int i = 13; i <= 25; i++) drive(4'(i), 1'b0);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_bin", 32'(bin_out), 32'(0));
        chk("async_dir", 32'(dir), 32'(0));
        chk("async_valid", 32'(pos_valid), 32'(0));
        sb.delete();
        gray_in = 4'b1101;
        @(posedge clk);
        seed_check(4'd9);
        drive(4'd8, 1'b0);

        chk("pulse_total", 32'(pulses), 32'(exp_pulses));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
